obstacle_scroller: RTL and testbench
====================================

OBSTACLE_SCROLLER -- requirements
Module: obstacle_scroller

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_BLOCKS, 4, number of independent obstacles.
- COORD_W, 11, x coordinate width.
- Y_W, 10, y coordinate width.
- SCREEN_W, 640, screen width in pixels.
- BLOCK_W, 16, obstacle width in pixels.
- SPACING, 160, reset-time x pitch between obstacles.
- GROUND_TOP, 400, y of a ground obstacle.
- AIR_OFFSET, 15, upward y offset of an airborne obstacle.
- GAP_W, 5, random respawn gap width; the gap range is 0..2^GAP_W-1.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- slowed_clock, in, 1, game tick clock.
- reset, in, 1, synchronous active-high reset.
- enable, in, 1, advance one game step this cycle.
- speed, in, 3, pixels moved per step.
- block_x, out, NUM_BLOCKS*COORD_W, right edge of block i in slice i (block i occupies [x-BLOCK_W, x-1]).
- block_y, out, NUM_BLOCKS*Y_W, top of block i.
- block_air, out, NUM_BLOCKS, block i is airborne.
- respawn, out, NUM_BLOCKS, one-cycle pulse when block i respawns.
- respawn_count, out, 16, total respawns; wraps modulo 2^16.
REQ-003 There SHALL be one clock; reset is synchronous and active-high (slowed_clock, reset).

Function
REQ-004 Each block's x SHALL be stored as its unsigned right edge, so the coordinate never goes negative.
REQ-005 All outputs SHALL be registered and SHALL update only on the rising edge of slowed_clock.
REQ-006 The 16-bit Fibonacci LFSR SHALL use taps 16,14,13,11 and SHALL advance once per cycle with enable=1; it holds otherwise.
REQ-007 Block i SHALL be eligible to respawn when x_i <= speed.
REQ-008 With enable=1, a non-eligible block SHALL take x_i <= x_i - speed; the result is always >= 1.
REQ-009 When one or more blocks are eligible, only the lowest-index eligible block SHALL respawn that cycle.
- Other eligible blocks hold x and y unchanged.
- They respawn on later enabled cycles in index order.
REQ-010 A respawning block SHALL load values from the pre-advance LFSR value L:
- x <= SCREEN_W + BLOCK_W + L[GAP_W-1:0].
- block_air <= L[15].
- y <= GROUND_TOP - AIR_OFFSET if L[15]=1, else GROUND_TOP.
- respawn[i] pulses high for exactly that cycle.
- respawn_count increments by 1.
REQ-011 With speed=0 no block SHALL move and no block SHALL respawn; the LFSR still advances.
REQ-012 With enable=0, all block state and respawn_count SHALL hold, and respawn SHALL be all zero.
REQ-013 At most one bit of respawn SHALL be high in any cycle.
REQ-014 Arithmetic SHALL be unsigned at COORD_W+1 bits, truncated to COORD_W on store.
- The integrator must size COORD_W to hold SCREEN_W + BLOCK_W + 2^GAP_W - 1 and the largest reset x.

Reset
REQ-015 On reset=1 at a clock edge, block i SHALL take:
- x = SCREEN_W + BLOCK_W + i*SPACING.
- y = GROUND_TOP.
- block_air = 0.
REQ-016 On the same reset edge the remaining state SHALL clear:
- respawn = 0.
- respawn_count = 0.
- LFSR = LFSR_SEED.
REQ-017 Reset SHALL take priority over enable, including when a respawn is pending in that cycle.

Verification
REQ-018 The bench SHALL cover these directed scenarios (default parameters unless stated):
- Reset: assert reset 1 cycle -> x = 656, 816, 976, 1136; all y=400; block_air=0; respawn_count=0.
- Scroll and respawn: speed=1, enable=1 for 655 cycles -> block0 x=1. Next cycle -> respawn=4'b0001, block0 x in [656,687], block1 x=160, respawn_count=1.
- Hold conditions: enable=0 for 50 cycles -> all outputs unchanged. Then speed=0, enable=1 -> x unchanged and no respawn.
- Simultaneous eligibility: SPACING=0 override, speed=7, run until x<=7 -> respawn pulses 0001, 0010, 0100, 1000 on 4 consecutive cycles, with waiting blocks holding x.
- Air/ground and LFSR: compare every respawn's x, y and block_air against a reference LFSR model. Over 1000 respawns, both y values (385 and 400) must occur and no gap may exceed 31.
- Reset mid-operation: assert reset in the same cycle a block is eligible -> no respawn pulse and REQ-015/REQ-016 values restored. Replaying the stimulus reproduces an identical respawn sequence.

Source files
------------

// File: rtl/obstacle_scroller.sv
// Side-scrolling obstacle field: NUM_BLOCKS blocks slide left by `speed`
// pixels per enabled tick and respawn past the right screen edge at a
// pseudo-random gap and height.
module obstacle_scroller #(
    parameter int          NUM_BLOCKS = 4,
    parameter int          COORD_W    = 11,
    parameter int          Y_W        = 10,
    parameter int          SCREEN_W   = 640,
    parameter int          BLOCK_W    = 16,
    parameter int          SPACING    = 160,
    parameter int          GROUND_TOP = 400,
    parameter int          AIR_OFFSET = 15,
    parameter int          GAP_W      = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                          slowed_clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [2:0]                    speed,
    output logic [NUM_BLOCKS*COORD_W-1:0] block_x,
    output logic [NUM_BLOCKS*Y_W-1:0]     block_y,
    output logic [NUM_BLOCKS-1:0]         block_air,
    output logic [NUM_BLOCKS-1:0]         respawn,
    output logic [15:0]                   respawn_count
);

    localparam logic [COORD_W:0] SPAWN_BASE = (COORD_W+1)'(SCREEN_W + BLOCK_W);
    localparam logic [Y_W-1:0]   Y_GROUND   = Y_W'(GROUND_TOP);
    localparam logic [Y_W-1:0]   Y_AIR      = Y_W'(GROUND_TOP - AIR_OFFSET);

    // x is kept as the block's right edge so it stays positive while the
    // block's left edge slides off screen.
    logic [COORD_W-1:0]    x_q [NUM_BLOCKS];
    logic [COORD_W-1:0]    x_d [NUM_BLOCKS];
    logic [Y_W-1:0]        y_q [NUM_BLOCKS];
    logic [Y_W-1:0]        y_d [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] air_q, air_d;
    logic [NUM_BLOCKS-1:0] respawn_q, respawn_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           lfsr_q, lfsr_d;

    logic [COORD_W:0]      speed_w;
    logic                  lfsr_fb;
    logic                  claimed;

    function automatic logic [COORD_W-1:0] reset_x(input int idx);
        return COORD_W'(SCREEN_W + BLOCK_W + idx * SPACING);
    endfunction

    // Next-state: advance the field one step; only the lowest-index eligible
    // block respawns, the others wait in place for later ticks.
    always_comb begin
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
        end
        air_d     = air_q;
        respawn_d = '0;
        count_d   = count_q;
        lfsr_d    = lfsr_q;
        claimed   = 1'b0;
        speed_w   = (COORD_W+1)'(speed);
        lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

        if (enable) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                if ({1'b0, x_q[i]} <= speed_w) begin
                    if (!claimed) begin
                        claimed      = 1'b1;
                        x_d[i]       = COORD_W'(SPAWN_BASE + (COORD_W+1)'(lfsr_q[GAP_W-1:0]));
                        air_d[i]     = lfsr_q[15];
                        y_d[i]       = lfsr_q[15] ? Y_AIR : Y_GROUND;
                        respawn_d[i] = 1'b1;
                    end
                end else begin
                    x_d[i] = COORD_W'({1'b0, x_q[i]} - speed_w);
                end
            end
            if (claimed) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    // State register with synchronous reset taking priority over enable.
    always_ff @(posedge slowed_clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                x_q[i] <= reset_x(i);
                y_q[i] <= Y_GROUND;
            end
            air_q     <= '0;
            respawn_q <= '0;
            count_q   <= '0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            air_q     <= air_d;
            respawn_q <= respawn_d;
            count_q   <= count_d;
            lfsr_q    <= lfsr_d;
        end
    end

    // Pack per-block registers onto the flat output buses.
    always_comb begin
        block_x = '0;
        block_y = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            block_x[i*COORD_W +: COORD_W] = x_q[i];
            block_y[i*Y_W +: Y_W]         = y_q[i];
        end
    end

    assign block_air     = air_q;
    assign respawn       = respawn_q;
    assign respawn_count = count_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller: a default-spacing and a zero-spacing instance
// share stimulus; a reference model feeds a per-cycle scoreboard queue.
module tb_obstacle_scroller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en;
    logic [2:0]  spd;
    logic [43:0] bx0, bx1;
    logic [39:0] by0, by1;
    logic [3:0]  ba0, ba1, rs0, rs1;
    logic [15:0] rc0, rc1;

    obstacle_scroller dut0 (
        .slowed_clock(clk), .reset(rst), .enable(en), .speed(spd),
        .block_x(bx0), .block_y(by0), .block_air(ba0), .respawn(rs0), .respawn_count(rc0)
    );

    obstacle_scroller #(.SPACING(0)) dut1 (
        .slowed_clock(clk), .reset(rst), .enable(en), .speed(spd),
        .block_x(bx1), .block_y(by1), .block_air(ba1), .respawn(rs1), .respawn_count(rc1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model state, index 0 = dut0 (spacing 160), 1 = dut1 (spacing 0)
    int          m_x   [2][4];
    logic [9:0]  m_y   [2][4];
    logic        m_air [2][4];
    logic [3:0]  m_rs  [2];
    logic [15:0] m_cnt [2];
    logic [15:0] m_l;

    typedef struct {
        logic [43:0] x;
        logic [39:0] y;
        logic [3:0]  air;
        logic [3:0]  rs;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];

    // Statistics and replay logs
    int          n_resp    = 0;
    bit          seen_air  = 0;
    bit          seen_gnd  = 0;
    bit          bad_gap   = 0;
    int          log_sel   = 0;
    int          log_cyc   = 0;
    logic [63:0] log_a[$];
    logic [63:0] log_b[$];

    task automatic model_step(input bit r, input bit e, input logic [2:0] s);
        logic [15:0] l;
        bit          done;
        exp_t        ex;
        l = m_l;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                for (int i = 0; i < 4; i++) begin
                    m_x[d][i]   = 656 + i * ((d == 0) ? 160 : 0);
                    m_y[d][i]   = 10'd400;
                    m_air[d][i] = 1'b0;
                end
                m_rs[d]  = 4'd0;
                m_cnt[d] = 16'd0;
            end else if (e) begin
                done    = 0;
                m_rs[d] = 4'd0;
                for (int i = 0; i < 4; i++) begin
                    if (m_x[d][i] <= int'(s)) begin
                        if (!done) begin
                            done        = 1;
                            m_x[d][i]   = 656 + int'(l[4:0]);
                            m_air[d][i] = l[15];
                            m_y[d][i]   = l[15] ? 10'd385 : 10'd400;
                            m_rs[d][i]  = 1'b1;
                            m_cnt[d]    = m_cnt[d] + 16'd1;
                        end
                    end else begin
                        m_x[d][i] = m_x[d][i] - int'(s);
                    end
                end
            end else begin
                m_rs[d] = 4'd0;
            end
            for (int i = 0; i < 4; i++) begin
                ex.x[i*11 +: 11] = 11'(m_x[d][i]);
                ex.y[i*10 +: 10] = m_y[d][i];
                ex.air[i]        = m_air[d][i];
            end
            ex.rs  = m_rs[d];
            ex.cnt = m_cnt[d];
            sbq.push_back(ex);
        end
        if (r)      m_l = 16'hACE1;
        else if (e) m_l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endtask

    task automatic cycle(input bit r, input bit e, input logic [2:0] s);
        exp_t ex;
        int   gap;
        rst = r; en = e; spd = s;
        model_step(r, e, s);
        @(posedge clk);
        #1;
        ex = sbq.pop_front();
        check("d0_x",   64'(bx0), 64'(ex.x));
        check("d0_y",   64'(by0), 64'(ex.y));
        check("d0_air", 64'(ba0), 64'(ex.air));
        check("d0_rsp", 64'(rs0), 64'(ex.rs));
        check("d0_cnt", 64'(rc0), 64'(ex.cnt));
        ex = sbq.pop_front();
        check("d1_x",   64'(bx1), 64'(ex.x));
        check("d1_y",   64'(by1), 64'(ex.y));
        check("d1_air", 64'(ba1), 64'(ex.air));
        check("d1_rsp", 64'(rs1), 64'(ex.rs));
        check("d1_cnt", 64'(rc1), 64'(ex.cnt));
        if (rs0 != 4'd0) begin
            n_resp++;
            for (int i = 0; i < 4; i++) begin
                if (rs0[i]) begin
                    gap = int'(bx0[i*11 +: 11]) - 656;
                    if (gap < 0 || gap > 31) bad_gap = 1;
                    if (by0[i*10 +: 10] == 10'd385) seen_air = 1;
                    if (by0[i*10 +: 10] == 10'd400) seen_gnd = 1;
                end
            end
        end
        if (log_sel != 0) begin
            if (rs0 != 4'd0) begin
                if (log_sel == 1) log_a.push_back({16'(log_cyc), rs0, bx0});
                else              log_b.push_back({16'(log_cyc), rs0, bx0});
            end
            log_cyc++;
        end
    endtask

    typedef struct {
        bit         r;
        bit         e;
        logic [2:0] s;
        int         n;
        int         ex[4];
        int         ecnt;
    } vec_t;

    vec_t vt[4];

    task automatic set_vec(input int k, input bit r, input bit e, input logic [2:0] s, input int n,
                           input int x0, input int x1, input int x2, input int x3, input int c);
        vt[k].r = r; vt[k].e = e; vt[k].s = s; vt[k].n = n;
        vt[k].ex[0] = x0; vt[k].ex[1] = x1; vt[k].ex[2] = x2; vt[k].ex[3] = x3;
        vt[k].ecnt = c;
    endtask

    initial begin
        int  budget;
        bit  found;
        rst = 1'b1; en = 1'b0; spd = 3'd0;

        set_vec(0, 1, 0, 3'd0, 1,   656, 816, 976, 1136, 0);
        set_vec(1, 0, 1, 3'd1, 655, 1,   161, 321, 481,  0);
        set_vec(2, 0, 0, 3'd1, 50,  1,   161, 321, 481,  0);
        set_vec(3, 0, 1, 3'd0, 10,  1,   161, 321, 481,  0);

        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < vt[v].n; c++) cycle(vt[v].r, vt[v].e, vt[v].s);
            for (int i = 0; i < 4; i++)
                check($sformatf("vec%0d_x%0d", v, i), 64'(bx0[i*11 +: 11]), 64'(vt[v].ex[i]));
            check($sformatf("vec%0d_cnt", v), 64'(rc0), 64'(vt[v].ecnt));
            check($sformatf("vec%0d_rsp", v), 64'(rs0), 64'd0);
            if (v == 0) begin
                check("reset_y",   64'(by0), 64'({10'd400, 10'd400, 10'd400, 10'd400}));
                check("reset_air", 64'(ba0), 64'd0);
            end
        end

        // First respawn after the long scroll
        cycle(0, 1, 3'd1);
        check("first_rsp",       64'(rs0), 64'd1);
        check("first_x_range",   64'(bx0[10:0] >= 11'd656 && bx0[10:0] <= 11'd687), 64'd1);
        check("first_x1",        64'(bx0[21:11]), 64'd160);
        check("first_cnt",       64'(rc0), 64'd1);
        check("first_d1_rsp",    64'(rs1), 64'd1);
        check("first_d1_hold",   64'(bx1[21:11]), 64'd1);

        // Simultaneous eligibility on the zero-spacing instance
        cycle(1, 0, 3'd0);
        for (int c = 0; c < 93; c++) cycle(0, 1, 3'd7);
        for (int i = 0; i < 4; i++)
            check($sformatf("sim_pre_x%0d", i), 64'(bx1[i*11 +: 11]), 64'd5);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 3'd7);
            check($sformatf("sim_rsp%0d", k), 64'(rs1), 64'(4'b0001 << k));
            for (int j = k + 1; j < 4; j++)
                check($sformatf("sim_hold%0d_%0d", k, j), 64'(bx1[j*11 +: 11]), 64'd5);
        end

        // Long run for LFSR-driven height and gap statistics
        budget = 0;
        while (n_resp < 1000 && budget < 60000) begin
            cycle(0, 1, 3'd7);
            budget++;
        end
        check("resp_1000_reached", 64'(n_resp >= 1000), 64'd1);
        check("seen_air_y",        64'(seen_air), 64'd1);
        check("seen_ground_y",     64'(seen_gnd), 64'd1);
        check("gap_in_range",      64'(bad_gap), 64'd0);

        // Reset arriving while a block is eligible
        cycle(1, 0, 3'd0);
        found  = 0;
        budget = 0;
        while (!found && budget < 300) begin
            cycle(0, 1, 3'd5);
            budget++;
            for (int i = 0; i < 4; i++) if (m_x[0][i] <= 5) found = 1;
        end
        check("eligible_found", 64'(found), 64'd1);
        cycle(1, 1, 3'd5);
        check("midrst_rsp", 64'(rs0), 64'd0);
        check("midrst_x",   64'(bx0), 64'({11'd1136, 11'd976, 11'd816, 11'd656}));
        check("midrst_cnt", 64'(rc0), 64'd0);
        check("midrst_air", 64'(ba0), 64'd0);

        // Replay: identical stimulus after reset gives identical respawns
        log_sel = 1; log_cyc = 0;
        for (int c = 0; c < 400; c++) cycle(0, 1, 3'd5);
        log_sel = 0;
        cycle(1, 0, 3'd0);
        log_sel = 2; log_cyc = 0;
        for (int c = 0; c < 400; c++) cycle(0, 1, 3'd5);
        log_sel = 0;
        check("replay_nonempty", 64'(log_a.size() > 0), 64'd1);
        check("replay_size",     64'(log_b.size()), 64'(log_a.size()));
        for (int i = 0; i < log_a.size() && i < log_b.size(); i++)
            check($sformatf("replay_ev%0d", i), log_b[i], log_a[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
